load_store_unit: RTL

//  Initiator side of the CPU data-memory interface: accepts one load/store request from the execute stage, drives

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_align.sv | 46 ++++
 rtl/load_store_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM states and
// small helpers for access width, misalignment and natural alignment.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, ERR, RESP} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Unsupported funct3 encodings fall into the word case.
  function automatic lsu_size_t access_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (access_size(f3))
      SZ_H:    return off[0];
      SZ_W:    return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] natural_offset(input logic [2:0] f3, input logic [1:0] off);
    case (access_size(f3))
      SZ_H:    return {off[1], 1'b0};
      SZ_W:    return 2'b00;
      default: return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts and extends load data from a memory word and
// merges sub-word store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] store_data,
  input  logic [31:0] merge_word,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  byte_en;
  logic [31:0] lane_data;

  always_comb begin
    ld_byte   = load_word[{offset, 3'b000} +: 8];
    ld_half   = offset[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    byte_en   = 4'b1111;
    lane_data = store_data;
    case (access_size(funct3))
      SZ_B: begin
        load_data = (funct3 == F3_B) ? {{24{ld_byte[7]}}, ld_byte} : {24'b0, ld_byte};
        byte_en   = 4'b0001 << offset;
        lane_data = {4{store_data[7:0]}};
      end
      SZ_H: begin
        load_data = (funct3 == F3_H) ? {{16{ld_half[15]}}, ld_half} : {16'b0, ld_half};
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Store data is replicated across lanes, so each byte just picks old or new.
  for (genvar gi = 0; gi < 4; gi++) begin : g_merge
    assign merged_word[8*gi +: 8] = byte_en[gi] ? lane_data[8*gi +: 8] : merge_word[8*gi +: 8];
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit for a word-addressed data memory with sub-word RMW stores.
// Build option LSU_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int MEM_BYTES = 1024
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_is_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_misaligned,
  output logic            resp_fault,
  output logic [XLEN-1:0] address,
  output logic [XLEN-1:0] write_data,
  output logic            MemRead,
  output logic            MemWrite,
  input  logic [XLEN-1:0] read_data
);

  lsu_state_t      state_reg;
  logic [2:0]      funct3_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] wdata_reg;
  logic [XLEN-1:0] merge_reg;
  logic            is_store_reg;
  logic            resp_valid_reg;
  logic [XLEN-1:0] resp_rdata_reg;
  logic            resp_misaligned_reg;
  logic            resp_fault_reg;

  logic            req_fault;
  logic            req_mis;
  logic [XLEN-1:0] accept_addr;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged_word;

  assign req_fault = req_addr >= XLEN'(MEM_BYTES);

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_mis     = is_misaligned(req_funct3, req_addr[1:0]);
  assign accept_addr = req_addr;
`else
  assign req_mis     = 1'b0;
  assign accept_addr = {req_addr[XLEN-1:2], natural_offset(req_funct3, req_addr[1:0])};
`endif

  lsu_align u_align (
    .funct3      (funct3_reg),
    .offset      (addr_reg[1:0]),
    .load_word   (read_data),
    .store_data  (wdata_reg),
    .merge_word  (merge_reg),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Errors report on entry to ERR (1-cycle latency); the following RESP cycle is
  // then silent so every request yields exactly one resp_valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      funct3_reg          <= F3_W;
      addr_reg            <= '0;
      wdata_reg           <= '0;
      merge_reg           <= '0;
      is_store_reg        <= 1'b0;
      resp_valid_reg      <= 1'b0;
      resp_rdata_reg      <= '0;
      resp_misaligned_reg <= 1'b0;
      resp_fault_reg      <= 1'b0;
    end else begin
      resp_valid_reg      <= 1'b0;
      resp_rdata_reg      <= '0;
      resp_misaligned_reg <= 1'b0;
      resp_fault_reg      <= 1'b0;
      case (state_reg)
        IDLE: if (req_valid) begin
          funct3_reg   <= req_funct3;
          addr_reg     <= accept_addr;
          wdata_reg    <= req_wdata;
          is_store_reg <= req_is_store;
          if (req_fault || req_mis) begin
            state_reg           <= ERR;
            resp_valid_reg      <= 1'b1;
            resp_fault_reg      <= req_fault;
            resp_misaligned_reg <= !req_fault && req_mis;
          end else if (req_is_store && access_size(req_funct3) != SZ_W) begin
            state_reg <= RMW_RD;
          end else begin
            state_reg <= ACCESS;
          end
        end
        ACCESS: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
          if (!is_store_reg) resp_rdata_reg <= load_data;
        end
        RMW_RD: begin
          merge_reg <= read_data;
          state_reg <= RMW_WR;
        end
        RMW_WR: begin
          state_reg      <= RESP;
          resp_valid_reg <= 1'b1;
        end
        ERR:     state_reg <= RESP;
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready       = (state_reg == IDLE);
  assign resp_valid      = resp_valid_reg;
  assign resp_rdata      = resp_rdata_reg;
  assign resp_misaligned = resp_misaligned_reg;
  assign resp_fault      = resp_fault_reg;
  assign address         = {addr_reg[XLEN-1:2], 2'b00};

  assign MemRead  = !reset && ((state_reg == ACCESS && !is_store_reg) || state_reg == RMW_RD);
  assign MemWrite = !reset && ((state_reg == ACCESS && is_store_reg) || state_reg == RMW_WR);

  always_comb begin
    write_data = '0;
    if (state_reg == ACCESS && is_store_reg) write_data = wdata_reg;
    else if (state_reg == RMW_WR)            write_data = merged_word;
  end

endmodule
